// File: rtl/div_16bit_ctrl_pkg.sv
// Shared types and constants for the div_16bit handshake wrapper.
// Contents: FSM state enum, operand widths, divide-by-zero quotient.
// Imported by the interface, the control block and the self-check block.
package div_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;

    localparam logic [DIVIDEND_W-1:0] DIV0_QUOTIENT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div_16bit_ctrl_if.sv
// Request/response channels of the divider wrapper (valid/ready both ways).
// Request: in_valid, in_ready, in_dividend, in_divisor.
// Response: out_valid, out_ready, out_quotient, out_remainder, out_div0
// (+ out_err when DIV_16BIT_SELFCHECK_EN is defined).
// master = requester/consumer side, slave = div_16bit_ctrl.
interface div_16bit_ctrl_if;
    import div_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] in_dividend;
    logic [DIVISOR_W-1:0]  in_divisor;

    logic                  out_valid;
    logic                  out_ready;
    logic [DIVIDEND_W-1:0] out_quotient;
    logic [DIVIDEND_W-1:0] out_remainder;
    logic                  out_div0;
`ifdef DIV_16BIT_SELFCHECK_EN
    logic                  out_err;
`endif

    modport master (
        output in_valid, in_dividend, in_divisor, out_ready,
        input  in_ready, out_valid, out_quotient, out_remainder, out_div0
`ifdef DIV_16BIT_SELFCHECK_EN
        , input out_err
`endif
    );

    modport slave (
        input  in_valid, in_dividend, in_divisor, out_ready,
        output in_ready, out_valid, out_quotient, out_remainder, out_div0
`ifdef DIV_16BIT_SELFCHECK_EN
        , output out_err
`endif
    );

endinterface

// File: rtl/div_16bit_ctrl_selfcheck.sv
// Combinational consistency check of a divider result against its operands.
// Ports: a_i dividend, b_i divisor, quo_i quotient, rem_i remainder,
//        err_o high when quo*b + rem != a (32-bit) or rem >= b.
// Only instantiated when DIV_16BIT_SELFCHECK_EN is defined.
module div_16bit_selfcheck
    import div_pkg::*;
(
    input  logic [DIVIDEND_W-1:0] a_i,
    input  logic [DIVISOR_W-1:0]  b_i,
    input  logic [DIVIDEND_W-1:0] quo_i,
    input  logic [DIVIDEND_W-1:0] rem_i,
    output logic                  err_o
);

    logic [31:0] recon;

    // Full 32-bit reconstruction so a wrapped product cannot alias a good result.
    assign recon = (32'(quo_i) * 32'(b_i)) + 32'(rem_i);
    assign err_o = (recon != 32'(a_i)) || (rem_i >= 16'(b_i));

endmodule

// File: rtl/div_16bit_ctrl.sv
// Handshake wrapper around the combinational 16/8 divider div_16bit.
// Ports: clk, rst (async, active high); io (div_16bit_ctrl_if.slave) request and
//        response channels; div_a/div_b registered operands to the divider;
//        div_result/div_odd divider outputs; busy = not IDLE.
// Latency: result registered SETTLE_CYCLES edges after accept; divide-by-zero
//          result is loaded on the accept edge. Result is held while out_ready is low.
// Optional: DIV_16BIT_SELFCHECK_EN adds io.out_err (result consistency flag).
module div_16bit_ctrl
    import div_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2   // legal 1..15
) (
    input  logic                  clk,
    input  logic                  rst,
    div_16bit_ctrl_if.slave       io,
    output logic [DIVIDEND_W-1:0] div_a,
    output logic [DIVISOR_W-1:0]  div_b,
    input  logic [DIVIDEND_W-1:0] div_result,
    input  logic [DIVIDEND_W-1:0] div_odd,
    output logic                  busy
);

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] a_q, a_d;
    logic [DIVISOR_W-1:0]  b_q, b_d;
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVIDEND_W-1:0] rem_q, rem_d;
    logic                  div0_q, div0_d;
`ifdef DIV_16BIT_SELFCHECK_EN
    logic                  err_q, err_d;
    logic                  chk_err;

    div_16bit_selfcheck u_selfcheck (
        .a_i   (a_q),
        .b_i   (b_q),
        .quo_i (div_result),
        .rem_i (div_odd),
        .err_o (chk_err)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            div0_q  <= 1'b0;
`ifdef DIV_16BIT_SELFCHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            div0_q  <= div0_d;
`ifdef DIV_16BIT_SELFCHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        div0_d  = div0_q;
`ifdef DIV_16BIT_SELFCHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    // Operands stay on the divider inputs until the next accept.
                    a_d = io.in_dividend;
                    b_d = io.in_divisor;
`ifdef DIV_16BIT_SELFCHECK_EN
                    err_d = 1'b0;
`endif
                    if (io.in_divisor != '0) begin
                        cnt_d   = CNT_INIT;
                        state_d = WAIT;
                    end else begin
                        // Zero divisor is answered locally; divider outputs unused.
                        quo_d   = DIV0_QUOTIENT;
                        rem_d   = io.in_dividend;
                        div0_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    quo_d   = div_result;
                    rem_d   = div_odd;
                    div0_d  = 1'b0;
`ifdef DIV_16BIT_SELFCHECK_EN
                    err_d   = chk_err;
`endif
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // in_ready is held low while reset is asserted so nothing is offered during it.
    assign io.in_ready      = (state_q == IDLE) && !rst;
    assign io.out_valid     = (state_q == DONE);
    assign io.out_quotient  = quo_q;
    assign io.out_remainder = rem_q;
    assign io.out_div0      = div0_q;
`ifdef DIV_16BIT_SELFCHECK_EN
    assign io.out_err       = err_q;
`endif
    assign div_a = a_q;
    assign div_b = b_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_div_16bit_ctrl.sv
// Bench for div_16bit_ctrl with a behavioural 16/8 divider attached.
// Expected results are pushed to a scoreboard at accept time and compared when
// the DUT offers a result; latency, stall, and mid-operation reset are checked.
module tb_div_16bit_ctrl;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] div_a;
    logic [7:0]  div_b;
    logic [15:0] div_result;
    logic [15:0] div_odd;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] quo;
        logic [15:0] rem;
        logic        div0;
    } exp_t;

    exp_t sb[$];

    div_16bit_ctrl_if intf();

    div_16bit_ctrl #(.SETTLE_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .io         (intf),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_result (div_result),
        .div_odd    (div_odd),
        .busy       (busy)
    );

    // Stand-in for the combinational div_16bit.
    assign div_result = (div_b == 8'd0) ? 16'hFFFF : div_a / {8'd0, div_b};
    assign div_odd    = (div_b == 8'd0) ? div_a    : div_a % {8'd0, div_b};

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Result monitor: sampled mid-cycle, ahead of the edge that consumes it.
    always @(negedge clk) begin
        if (intf.out_valid && intf.out_ready) begin
            if (sb.size() == 0) begin
                check_val("spurious_valid", 32'(intf.out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("quotient",  32'(intf.out_quotient),  32'(e.quo));
                check_val("remainder", 32'(intf.out_remainder), 32'(e.rem));
                check_val("div0",      32'(intf.out_div0),      32'(e.div0));
            end
        end
    end

    // Called #1 after a posedge. Returns #1 after the edge where out_valid is first seen.
    // lat = edges after the accept edge until out_valid is seen; a zero divisor is
    // answered on the accept edge itself, so its lat is 0.
    task automatic do_req(input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] q, input logic [15:0] r,
                          input logic d0, input int lat);
        int n;
        exp_t e;
        intf.in_dividend = a;
        intf.in_divisor  = b;
        intf.in_valid    = 1'b1;
        n = 0;
        while (!intf.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("in_ready_before_accept", 32'(intf.in_ready), 32'd1);
        @(posedge clk);
        e.quo = q; e.rem = r; e.div0 = d0;
        sb.push_back(e);
        #1;
        intf.in_valid    = 1'b0;
        intf.in_dividend = 16'($urandom);
        intf.in_divisor  = 8'($urandom);
        n = 0;
        while (!intf.out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("latency", 32'(n), 32'(lat));
`ifdef DIV_16BIT_SELFCHECK_EN
        check_val("out_err", 32'(intf.out_err), 32'd0);
`endif
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (intf.out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("drained", 32'(intf.out_valid), 32'd0);
    endtask

    initial begin
        rst              = 1'b1;
        intf.in_valid    = 1'b0;
        intf.in_dividend = '0;
        intf.in_divisor  = '0;
        intf.out_ready   = 1'b1;

        repeat (2) @(negedge clk);
        check_val("rst_out_valid", 32'(intf.out_valid),     32'd0);
        check_val("rst_quotient",  32'(intf.out_quotient),  32'd0);
        check_val("rst_remainder", 32'(intf.out_remainder), 32'd0);
        check_val("rst_div0",      32'(intf.out_div0),      32'd0);
        check_val("rst_div_a",     32'(div_a),              32'd0);
        check_val("rst_div_b",     32'(div_b),              32'd0);
        check_val("rst_busy",      32'(busy),               32'd0);

        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("in_ready_after_rst", 32'(intf.in_ready), 32'd1);
        @(posedge clk); #1;

        do_req(16'd100,   8'd7,    16'd14,     16'd2,  1'b0, 2); wait_drain();
        do_req(16'hFFFF,  8'd1,    16'hFFFF,   16'd0,  1'b0, 2); wait_drain();
        do_req(16'hFFFF,  8'hFF,   16'h0101,   16'd0,  1'b0, 2); wait_drain();
        do_req(16'd50,    8'd0,    16'hFFFF,   16'd50, 1'b1, 0); wait_drain();

        // Consumer stall with a second request already waiting.
        intf.out_ready = 1'b0;
        do_req(16'd1000, 8'd3, 16'd333, 16'd1, 1'b0, 2);
        intf.in_dividend = 16'd1234;
        intf.in_divisor  = 8'd10;
        intf.in_valid    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val("stall_out_valid", 32'(intf.out_valid),     32'd1);
            check_val("stall_in_ready",  32'(intf.in_ready),      32'd0);
            check_val("stall_quotient",  32'(intf.out_quotient),  32'd333);
            check_val("stall_remainder", 32'(intf.out_remainder), 32'd1);
            check_val("stall_div_a",     32'(div_a),              32'd1000);
            check_val("stall_div_b",     32'(div_b),              32'd3);
        end
        @(posedge clk); #1;
        intf.out_ready = 1'b1;
        do_req(16'd1234, 8'd10, 16'd123, 16'd4, 1'b0, 2); wait_drain();

        // Reset while in WAIT: the pending result must vanish.
        intf.in_dividend = 16'd1000;
        intf.in_divisor  = 8'd7;
        intf.in_valid    = 1'b1;
        @(posedge clk); #1;
        intf.in_valid = 1'b0;
        check_val("abort_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_rst_out_valid", 32'(intf.out_valid),     32'd0);
        check_val("mid_rst_quotient",  32'(intf.out_quotient),  32'd0);
        check_val("mid_rst_remainder", 32'(intf.out_remainder), 32'd0);
        check_val("mid_rst_div0",      32'(intf.out_div0),      32'd0);
        check_val("mid_rst_div_a",     32'(div_a),              32'd0);
        check_val("mid_rst_div_b",     32'(div_b),              32'd0);
        check_val("mid_rst_busy",      32'(busy),               32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("abort_no_valid", 32'(intf.out_valid), 32'd0);
        end
        @(posedge clk); #1;
        do_req(16'd9, 8'd3, 16'd3, 16'd0, 1'b0, 2); wait_drain();

        check_val("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
